// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer feeding the 16-bit ALU: fetch/decode/exec/writeback.
// Optional macro ALU_SEQ_BRANCH_EN enables the BZ conditional branch.
`timescale 1ns/1ps
module alu_seq_ctrl #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic [15:0]     alu_a,
   output logic [15:0]     alu_b,
   output logic [3:0]      alu_op,
   output logic            alu_rst,
   input  logic [15:0]     alu_y,
   input  logic            alu_flag,
   output logic            zflag,
   output logic            busy,
   output logic            halted,
   input  logic [1:0]      dbg_sel,
   output logic [15:0]     dbg_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t            state, nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [15:0]       ir, res;
   logic              rflag;
   logic [15:0]       rf [4];

   logic [3:0]        op;
   logic [1:0]        rd, ra, rb;
   logic [7:0]        imm8;
   logic              is_alu, is_ldi, is_halt;

   assign op   = ir[15:12];
   assign rd   = ir[11:10];
   assign ra   = ir[9:8];
   assign rb   = ir[7:6];
   assign imm8 = ir[7:0];

   assign imem_addr = pc;
   assign alu_a     = rf[ra];
   assign alu_b     = rf[rb];
   assign dbg_data  = rf[dbg_sel];

   always_comb begin
      is_alu  = 1'b0;
      is_ldi  = 1'b0;
      is_halt = 1'b0;
      unique case (op)
         4'b0001, 4'b0101,
         4'b0110, 4'b0111: is_alu  = 1'b1;
         4'b0010:          is_ldi  = 1'b1;
         4'b1111:          is_halt = 1'b1;
         default:          ;
      endcase
   end

`ifdef ALU_SEQ_BRANCH_EN
   // offset is sign-extended, PC wraps at PC_W bits
   always_comb begin
      if (op == 4'b1000 && zflag)
         pc_nxt = pc + PC_W'($signed(imm8));
      else
         pc_nxt = pc + PC_W'(1);
   end
`else
   assign pc_nxt = pc + PC_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE, S_HALT: if (start) nxt = S_FETCH;
         S_FETCH:        nxt = S_DECODE;
         S_DECODE:       nxt = S_EXEC;
         S_EXEC:         nxt = S_WB;
         S_WB:           nxt = is_halt ? S_HALT : S_FETCH;
         default:        nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      halted  = 1'b0;
      alu_rst = 1'b1;
      alu_op  = 4'b0000;
      unique case (state)
         S_FETCH, S_DECODE, S_WB: busy = 1'b1;
         S_EXEC: begin
            busy    = 1'b1;
            alu_rst = 1'b0;
            alu_op  = op;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc    <= '0;
         ir    <= '0;
         res   <= '0;
         rflag <= 1'b0;
         zflag <= 1'b0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_HALT: if (start) pc <= '0;
            S_DECODE: ir <= imem_data;
            S_EXEC: begin
               res   <= alu_y;
               rflag <= alu_flag;
            end
            S_WB: begin
               if (is_alu) begin
                  rf[rd] <= res;
                  zflag  <= rflag;
               end
               if (is_ldi) rf[rd] <= {8'h00, imm8};
               if (!is_halt) pc <= pc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: ROM + ALU models, lockstep ISA-level reference.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data = '0;
   logic [15:0] alu_a, alu_b, alu_y;
   logic [3:0]  alu_op;
   logic        alu_rst, alu_flag;
   logic        zflag, busy, halted;
   logic [1:0]  dbg_sel = '0;
   logic [15:0] dbg_data;

   int checks = 0;
   int failures = 0;

   logic [15:0] rom [256];

   logic [15:0] mr [4];
   logic        mz, mhalt;
   logic [7:0]  mpc;

   alu_seq_ctrl #(.PC_W(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_rst(alu_rst), .alu_y(alu_y), .alu_flag(alu_flag),
      .zflag(zflag), .busy(busy), .halted(halted),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= rom[imem_addr];

   // external ALU behaviour
   always_comb begin
      alu_y = '0;
      if (!alu_rst) begin
         case (alu_op)
            4'd1:    alu_y = alu_b + 16'd1;
            4'd5:    alu_y = alu_a + alu_b;
            4'd6:    alu_y = alu_a - alu_b;
            4'd7:    alu_y = alu_a ^ alu_b;
            default: alu_y = '0;
         endcase
      end
   end
   assign alu_flag = (alu_y == 16'd0);

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ea(input int op, rd, ra, rb);
      return {4'(op), 2'(rd), 2'(ra), 2'(rb), 6'd0};
   endfunction

   function automatic logic [15:0] ei(input int op, rd, imm);
      return {4'(op), 2'(rd), 2'd0, 8'(imm)};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
   endtask

   // one architectural instruction, straight from the ISA rules
   task automatic mstep();
      logic [15:0] ins, y;
      logic [3:0]  o;
      ins = rom[mpc];
      o   = ins[15:12];
      y   = '0;
      case (o)
         4'd1, 4'd5, 4'd6, 4'd7: begin
            case (o)
               4'd1:    y = mr[ins[7:6]] + 16'd1;
               4'd5:    y = mr[ins[9:8]] + mr[ins[7:6]];
               4'd6:    y = mr[ins[9:8]] - mr[ins[7:6]];
               default: y = mr[ins[9:8]] ^ mr[ins[7:6]];
            endcase
            mr[ins[11:10]] = y;
            mz  = (y == 16'd0);
            mpc = mpc + 8'd1;
         end
         4'd2: begin
            mr[ins[11:10]] = {8'h00, ins[7:0]};
            mpc = mpc + 8'd1;
         end
`ifdef ALU_SEQ_BRANCH_EN
         4'd8: mpc = mz ? mpc + ins[7:0] : mpc + 8'd1;
`endif
         4'd15: mhalt = 1'b1;
         default: mpc = mpc + 8'd1;
      endcase
   endtask

   task automatic check_regs(input string tag);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1;
         chk($sformatf("%s_r%0d", tag, r), dbg_data, mr[r]);
      end
      chk({tag, "_z"}, zflag, mz);
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int r = 0; r < 4; r++) mr[r] = '0;
      mz = 1'b0; mhalt = 1'b0; mpc = '0;
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_alurst", alu_rst, 1);
      chk("rst_aluop", alu_op, 0);
      chk("rst_pc", imem_addr, 0);
      check_regs("rst");
   endtask

   // run from pc 0 for up to maxi instructions in lockstep with the model
   task automatic run(input int maxi, input bit pulse);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mpc   = '0;
      mhalt = 1'b0;
      for (int i = 0; i < maxi; i++) begin
         chk("pc", imem_addr, mpc);
         chk("busy", busy, 1);
         for (int j = 0; j < 4; j++) begin
            start = pulse && (j == 1);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (j == 1) begin
               chk("alu_rst", alu_rst, 0);
               chk("alu_op", alu_op, rom[mpc][15:12]);
               chk("alu_a", alu_a, mr[rom[mpc][9:8]]);
            end
         end
         mstep();
         if (mhalt) begin
            chk("halted", halted, 1);
            chk("busy_h", busy, 0);
            chk("pc_h", imem_addr, mpc);
            break;
         end
      end
      check_regs("run");
   endtask

   initial begin
      do_reset();

      // add then subtract to zero
      clear_rom();
      rom[0] = ei(2, 0, 5);
      rom[1] = ei(2, 1, 3);
      rom[2] = ea(5, 2, 0, 1);
      rom[3] = ea(6, 3, 0, 0);
      run(10, 1'b0);
      dbg_sel = 2'd2; #1;
      chk("p1_r2", dbg_data, 16'h0008);
      chk("p1_z", zflag, 1);

      // INC wrap then BZ +2
      do_reset();
      clear_rom();
      rom[0] = ei(2, 0, 1);
      rom[1] = ea(7, 1, 1, 1);
      rom[2] = ea(6, 1, 1, 0);
      rom[3] = ea(1, 2, 0, 1);
      rom[4] = ei(8, 0, 2);
      rom[5] = ei(2, 3, 8'h55);
      run(10, 1'b0);
      dbg_sel = 2'd2; #1;
      chk("p2_r2", dbg_data, 16'h0000);

      // branch not taken
      do_reset();
      clear_rom();
      rom[0] = ei(2, 0, 1);
      rom[1] = ea(7, 1, 1, 1);
      rom[2] = ea(5, 2, 0, 1);
      rom[3] = ei(8, 0, -3);
      run(10, 1'b0);

      // backward wrap: second run starts with zflag set
      do_reset();
      clear_rom();
      rom[0] = ei(8, 0, 8'hFF);
      rom[1] = ea(7, 0, 0, 0);
      run(10, 1'b0);
      run(10, 1'b0);

      // reset during EXEC of ADD r2
      do_reset();
      clear_rom();
      rom[0] = ei(2, 0, 5);
      rom[1] = ei(2, 1, 3);
      rom[2] = ea(5, 2, 0, 1);
      run(2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("mid_exec", alu_rst, 0);
      do_reset();

      // unknown opcode with start pulses while busy
      clear_rom();
      rom[0] = ei(2, 0, 7);
      rom[1] = 16'h4ABC;
      run(10, 1'b1);
      dbg_sel = 2'd0; #1;
      chk("p6_r0", dbg_data, 16'h0007);

      // random programs
      for (int p = 0; p < 12; p++) begin
         do_reset();
         clear_rom();
         for (int i = 0; i < 12; i++)
            rom[i] = {4'($urandom_range(0, 15)), 12'($urandom)};
         run(40, p[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
